// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage: PC, byte-addressed little-endian instruction memory and IF/ID register.
// Handles stall, redirect with flush, and sticky fault on misaligned or out-of-range PC.
module instruction_fetch_stage #(
   parameter int          MEM_BYTES = 64,
   parameter logic [63:0] RESET_PC  = 64'd0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [63:0] redirect_pc,
   input  logic        mem_wr_en,
   input  logic [63:0] mem_wr_addr,
   input  logic [7:0]  mem_wr_data,
   output logic [31:0] instruction,
   output logic [63:0] pc_out,
   output logic        instr_valid,
   output logic        fetch_fault
);

   localparam int          AW        = $clog2(MEM_BYTES);
   localparam logic [63:0] LAST_WORD = 64'(MEM_BYTES - 4);
   localparam logic [63:0] MEM_LIMIT = 64'(MEM_BYTES);

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } state_t;

   state_t      state_r, stateNext_s;
   logic [63:0] pc_r, pcNext_s;
   logic [31:0] instr_r, instrNext_s;
   logic [63:0] pcOut_r, pcOutNext_s;
   logic        valid_r, validNext_s;
   logic        fault_r, faultNext_s;
   logic [7:0]  mem_r [MEM_BYTES];
   logic [AW-1:0] pcIdx_s;
   logic [31:0] fetchWord_s;

   // A fetchable address is word aligned and leaves a full word inside memory.
   function automatic logic pcOk(input logic [63:0] addr);
      return (addr[1:0] == 2'b00) && (addr <= LAST_WORD);
   endfunction

   // Program-load port; not reset so contents survive a reset pulse.
   always_ff @(posedge clk) begin
      if (mem_wr_en && (mem_wr_addr < MEM_LIMIT)) begin
         mem_r[mem_wr_addr[AW-1:0]] <= mem_wr_data;
      end
   end

   // Combinational little-endian word read at the current PC.
   always_comb begin
      pcIdx_s     = pc_r[AW-1:0];
      fetchWord_s = {mem_r[pcIdx_s + AW'(2'd3)], mem_r[pcIdx_s + AW'(2'd2)],
                     mem_r[pcIdx_s + AW'(2'd1)], mem_r[pcIdx_s]};
   end

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= BOOT;
      end else begin
         state_r <= stateNext_s;
      end
   end

   // Next-state selection: redirect outranks stall, stall outranks sequential fetch.
   always_comb begin
      stateNext_s = state_r;
      case (state_r)
         BOOT: begin
            if (redirect_valid) begin
               stateNext_s = pcOk(redirect_pc) ? RUN : HALT;
            end else begin
               stateNext_s = RUN;
            end
         end
         RUN: begin
            if (redirect_valid) begin
               stateNext_s = pcOk(redirect_pc) ? RUN : HALT;
            end else if (stall) begin
               stateNext_s = RUN;
            end else begin
               stateNext_s = pcOk(pc_r) ? RUN : HALT;
            end
         end
         HALT: begin
            if (redirect_valid && pcOk(redirect_pc)) begin
               stateNext_s = RUN;
            end else begin
               stateNext_s = HALT;
            end
         end
         default: stateNext_s = HALT;
      endcase
   end

   // Next values for PC and the IF/ID register.
   always_comb begin
      pcNext_s    = pc_r;
      instrNext_s = instr_r;
      pcOutNext_s = pcOut_r;
      validNext_s = valid_r;
      faultNext_s = fault_r;
      case (state_r)
         BOOT: begin
            validNext_s = 1'b0;
            if (redirect_valid) begin
               pcNext_s    = redirect_pc;
               faultNext_s = !pcOk(redirect_pc);
            end else begin
               pcNext_s = pc_r;
            end
         end
         RUN: begin
            if (redirect_valid) begin
               pcNext_s    = redirect_pc;
               validNext_s = 1'b0;
               faultNext_s = !pcOk(redirect_pc);
            end else if (stall) begin
               pcNext_s = pc_r;
            end else if (pcOk(pc_r)) begin
               instrNext_s = fetchWord_s;
               pcOutNext_s = pc_r;
               validNext_s = 1'b1;
               pcNext_s    = pc_r + 64'd4;
            end else begin
               validNext_s = 1'b0;
               faultNext_s = 1'b1;
            end
         end
         HALT: begin
            validNext_s = 1'b0;
            if (redirect_valid && pcOk(redirect_pc)) begin
               pcNext_s    = redirect_pc;
               faultNext_s = 1'b0;
            end else begin
               pcNext_s = pc_r;
            end
         end
         default: begin
            validNext_s = 1'b0;
            faultNext_s = 1'b1;
         end
      endcase
   end

   // PC and IF/ID register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_r    <= RESET_PC;
         instr_r <= 32'd0;
         pcOut_r <= 64'd0;
         valid_r <= 1'b0;
         fault_r <= 1'b0;
      end else begin
         pc_r    <= pcNext_s;
         instr_r <= instrNext_s;
         pcOut_r <= pcOutNext_s;
         valid_r <= validNext_s;
         fault_r <= faultNext_s;
      end
   end

   assign instruction = instr_r;
   assign pc_out      = pcOut_r;
   assign instr_valid = valid_r;
   assign fetch_fault = fault_r;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed bench for instruction_fetch_stage: program load, stall, redirect, fault and reset.
module tb_instruction_fetch_stage;

   logic        clk;
   logic        reset;
   logic        stall;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic        mem_wr_en;
   logic [63:0] mem_wr_addr;
   logic [7:0]  mem_wr_data;
   logic [31:0] instruction;
   logic [63:0] pc_out;
   logic        instr_valid;
   logic        fetch_fault;

   int total = 0;
   int bad   = 0;

   logic [7:0] prog [12] = '{8'h00, 8'h80, 8'hEF, 8'h01, 8'h00, 8'h80,
                             8'hCE, 8'h01, 8'h00, 8'h80, 8'hE7, 8'h00};

   instruction_fetch_stage #(.MEM_BYTES(64), .RESET_PC(64'd0)) dut (
      .clk(clk), .reset(reset), .stall(stall),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
      .instruction(instruction), .pc_out(pc_out),
      .instr_valid(instr_valid), .fetch_fault(fetch_fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One active edge, then settle on the falling edge for sampling/driving.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic expectFetch(input string tag, input logic [31:0] ins, input logic [63:0] pc);
      checkVal({tag, ".instr"}, {32'd0, instruction}, {32'd0, ins});
      checkVal({tag, ".pc"}, pc_out, pc);
      checkVal({tag, ".valid"}, {63'd0, instr_valid}, 64'd1);
   endtask

   task automatic runBootSequence(input string tag);
      reset = 1'b1;
      tick();
      checkVal({tag, ".boot_valid"}, {63'd0, instr_valid}, 64'd0);
      tick();
      expectFetch({tag, ".w0"}, 32'h01EF8000, 64'd0);
      tick();
      expectFetch({tag, ".w1"}, 32'h01CE8000, 64'd4);
      tick();
      expectFetch({tag, ".w2"}, 32'h00E78000, 64'd8);
   endtask

   initial begin
      reset          = 1'b0;
      stall          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 64'd0;
      mem_wr_en      = 1'b0;
      mem_wr_addr    = 64'd0;
      mem_wr_data    = 8'd0;
      #1;
      checkVal("reset.instr", {32'd0, instruction}, 64'd0);
      checkVal("reset.pc", pc_out, 64'd0);
      checkVal("reset.valid", {63'd0, instr_valid}, 64'd0);
      checkVal("reset.fault", {63'd0, fetch_fault}, 64'd0);
      @(negedge clk);

      // Program load while held in reset; bytes 12..63 carry their own address.
      for (int i = 0; i < 64; i++) begin
         mem_wr_en   = 1'b1;
         mem_wr_addr = 64'(i);
         mem_wr_data = (i < 12) ? prog[i] : 8'(i);
         tick();
      end
      // Out-of-range write must not alias onto byte 0.
      mem_wr_addr = 64'd64;
      mem_wr_data = 8'hFF;
      tick();
      mem_wr_en = 1'b0;

      // Test 1 start and test 2: stall holds outputs.
      reset = 1'b1;
      tick();
      checkVal("t1.boot_valid", {63'd0, instr_valid}, 64'd0);
      tick();
      expectFetch("t1.w0", 32'h01EF8000, 64'd0);
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         expectFetch($sformatf("t2.hold%0d", i), 32'h01EF8000, 64'd0);
      end
      stall = 1'b0;
      tick();
      expectFetch("t2.w1", 32'h01CE8000, 64'd4);
      tick();
      expectFetch("t1.w2", 32'h00E78000, 64'd8);

      // Test 3: redirect beats stall and flushes.
      redirect_valid = 1'b1;
      redirect_pc    = 64'd8;
      stall          = 1'b1;
      tick();
      checkVal("t3.flush", {63'd0, instr_valid}, 64'd0);
      redirect_valid = 1'b0;
      stall          = 1'b0;
      tick();
      expectFetch("t3.target", 32'h00E78000, 64'd8);

      // Test 4: misaligned redirect faults, good redirect recovers.
      redirect_valid = 1'b1;
      redirect_pc    = 64'd6;
      tick();
      redirect_valid = 1'b0;
      checkVal("t4.fault", {63'd0, fetch_fault}, 64'd1);
      checkVal("t4.valid", {63'd0, instr_valid}, 64'd0);
      stall = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         checkVal($sformatf("t4.halt_valid%0d", i), {63'd0, instr_valid}, 64'd0);
         checkVal($sformatf("t4.halt_fault%0d", i), {63'd0, fetch_fault}, 64'd1);
      end
      stall          = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = 64'd0;
      tick();
      redirect_valid = 1'b0;
      checkVal("t4.clear", {63'd0, fetch_fault}, 64'd0);
      checkVal("t4.bubble", {63'd0, instr_valid}, 64'd0);
      tick();
      expectFetch("t4.w0", 32'h01EF8000, 64'd0);

      // Test 5: run off the end of memory.
      repeat (15) tick();
      expectFetch("t5.last", 32'h3F3E3D3C, 64'd60);
      checkVal("t5.nofault", {63'd0, fetch_fault}, 64'd0);
      tick();
      checkVal("t5.fault", {63'd0, fetch_fault}, 64'd1);
      checkVal("t5.valid", {63'd0, instr_valid}, 64'd0);

      // Test 6: recover, then asynchronous reset between edges.
      redirect_valid = 1'b1;
      redirect_pc    = 64'd0;
      tick();
      redirect_valid = 1'b0;
      tick();
      expectFetch("t6.pre_w0", 32'h01EF8000, 64'd0);
      tick();
      #2;
      reset = 1'b0;
      #1;
      checkVal("t6.async_instr", {32'd0, instruction}, 64'd0);
      checkVal("t6.async_pc", pc_out, 64'd0);
      checkVal("t6.async_valid", {63'd0, instr_valid}, 64'd0);
      checkVal("t6.async_fault", {63'd0, fetch_fault}, 64'd0);
      @(negedge clk);
      runBootSequence("t6");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
